// File: rtl/wb_pdm_pkg.sv
// Shared constants for the PDM decimator: register map, STATUS bit layout
// and the CIC internal width derived from the decimation ratio.
package wb_pdm_pkg;

    localparam logic ADR_DATA   = 1'b0;
    localparam logic ADR_STATUS = 1'b1;

    localparam int STAT_LEVEL_LSB = 0;
    localparam int STAT_LEVEL_W   = 16;
    localparam int STAT_EMPTY     = 16;
    localparam int STAT_FULL      = 17;
    localparam int STAT_OVF       = 24;

    localparam int STAGES = 3;

    // Bit growth of an N-stage CIC is N*log2(R); one more bit holds the sign.
    function automatic int cic_width(input int decim);
        return STAGES * $clog2(decim) + 1;
    endfunction

endpackage

// File: rtl/wb_pdm_decim_if.sv
// Wishbone B4 pipelined bus bundle used between the CPU and the PDM decimator.
interface wb_pdm_decim_if;

    logic        cyc;
    logic        stb;
    logic        we;
    logic        adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        stall;
    logic        ack;

    modport master (
        output cyc, stb, we, adr, dat_w,
        input  dat_r, stall, ack
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w,
        output dat_r, stall, ack
    );

endinterface

// File: rtl/pcm_fifo.sv
// Synchronous sample FIFO; a push into a full FIFO is dropped unless a pop
// frees the slot in the same cycle.
module pcm_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic [LW-1:0]    level_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [LW-1:0]    lvl_q, lvl_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (lvl_q == '0);
    assign full_o  = (lvl_q == LW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_q];
    assign level_o = lvl_q;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        lvl_d = lvl_q;
        if (do_push) wr_d = wr_q + AW'(1);
        if (do_pop)  rd_d = rd_q + AW'(1);
        if (do_push && !do_pop) begin
            lvl_d = lvl_q + LW'(1);
        end else if (do_pop && !do_push) begin
            lvl_d = lvl_q - LW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            lvl_q <= lvl_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/wb_pdm_decim.sv
// 3rd-order CIC decimator turning a PDM bitstream into signed PCM samples,
// buffered in a FIFO that the CPU drains through a Wishbone read port.
module wb_pdm_decim
    import wb_pdm_pkg::*;
#(
    parameter int DECIM           = 64,
    parameter int AUDIO_BIT_DEPTH = 16,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    wb_pdm_decim_if.slave wb,
    input  logic          pdm_stb_i,
    input  logic          pdm_dat_i,
    output logic          irq_o
);

    localparam int W     = cic_width(DECIM);
    localparam int CW    = $clog2(DECIM);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    // +R^3 and -R^3 share the bit pattern 100..0 in W bits; the last input
    // bit of the window tells them apart (all ones vs all zeros).
    function automatic logic signed [AUDIO_BIT_DEPTH-1:0] scale_sat(
        input logic signed [W-1:0] v,
        input logic                pos
    );
        logic signed [W-1:0] most_neg;
        most_neg = {1'b1, {(W-1){1'b0}}};
        if (pos && (v == most_neg)) return {1'b0, {(AUDIO_BIT_DEPTH-1){1'b1}}};
        return v[W-1 -: AUDIO_BIT_DEPTH];
    endfunction

    logic signed [W-1:0] pdm_val;
    logic signed [W-1:0] int1_q, int1_d;
    logic signed [W-1:0] int2_q, int2_d;
    logic signed [W-1:0] int3_q, int3_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                vld_p1_q, vld_p1_d;
    logic                last_p1_q, last_p1_d;

    logic signed [W-1:0] c1, c2, c3;
    logic signed [W-1:0] dly1_q, dly1_d;
    logic signed [W-1:0] dly2_q, dly2_d;
    logic signed [W-1:0] dly3_q, dly3_d;
    logic signed [W-1:0] comb_p2_q, comb_p2_d;
    logic                vld_p2_q, vld_p2_d;
    logic                last_p2_q, last_p2_d;

    logic [AUDIO_BIT_DEPTH-1:0] push_data;
    logic [AUDIO_BIT_DEPTH-1:0] fifo_head;
    logic [LVL_W-1:0]           fifo_level;
    logic                       fifo_full;
    logic                       fifo_empty;

    logic        req;
    logic        rd_data;
    logic        ovf_set, ovf_clr;
    logic        ovf_q, ovf_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] status;
    logic        unused_wdat;

    // Stage p0: integrators and decimation counter, advanced per PDM bit
    always_comb begin
        pdm_val   = pdm_dat_i ? W'(1) : '1;
        int1_d    = int1_q;
        int2_d    = int2_q;
        int3_d    = int3_q;
        cnt_d     = cnt_q;
        vld_p1_d  = 1'b0;
        last_p1_d = last_p1_q;
        if (pdm_stb_i) begin
            int1_d = int1_q + pdm_val;
            int2_d = int2_q + int1_d;
            int3_d = int3_q + int2_d;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(DECIM - 1)) begin
                vld_p1_d  = 1'b1;
                last_p1_d = pdm_dat_i;
            end
        end
    end

    // Stage p1: comb chain evaluated once per decimated sample
    always_comb begin
        c1        = int3_q - dly1_q;
        c2        = c1 - dly2_q;
        c3        = c2 - dly3_q;
        dly1_d    = dly1_q;
        dly2_d    = dly2_q;
        dly3_d    = dly3_q;
        comb_p2_d = comb_p2_q;
        last_p2_d = last_p2_q;
        vld_p2_d  = vld_p1_q;
        if (vld_p1_q) begin
            dly1_d    = int3_q;
            dly2_d    = c1;
            dly3_d    = c2;
            comb_p2_d = c3;
            last_p2_d = last_p1_q;
        end
    end

    // Stage p2: scale, saturate and push into the FIFO
    assign push_data = scale_sat(comb_p2_q, last_p2_q);

    pcm_fifo #(
        .WIDTH (AUDIO_BIT_DEPTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_ni  (wb_rst_ni),
        .push_i  (vld_p2_q),
        .pop_i   (rd_data),
        .data_i  (push_data),
        .data_o  (fifo_head),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign req     = wb.cyc && wb.stb;
    assign rd_data = req && !wb.we && (wb.adr == ADR_DATA);
    assign ovf_set = vld_p2_q && fifo_full && !rd_data;
    assign ovf_clr = req && wb.we && (wb.adr == ADR_STATUS) && wb.dat_w[STAT_OVF];

    always_comb begin
        status = '0;
        status[STAT_LEVEL_LSB +: STAT_LEVEL_W] = STAT_LEVEL_W'(fifo_level);
        status[STAT_EMPTY] = fifo_empty;
        status[STAT_FULL]  = fifo_full;
        status[STAT_OVF]   = ovf_q;
    end

    always_comb begin
        ovf_d = ovf_set || (ovf_q && !ovf_clr);
        ack_d = req;
        dat_d = '0;
        if (req && !wb.we) begin
            if (wb.adr == ADR_STATUS) begin
                dat_d = status;
            end else if (!fifo_empty) begin
                dat_d = {{(32-AUDIO_BIT_DEPTH){fifo_head[AUDIO_BIT_DEPTH-1]}}, fifo_head};
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            int1_q    <= '0;
            int2_q    <= '0;
            int3_q    <= '0;
            cnt_q     <= '0;
            vld_p1_q  <= 1'b0;
            last_p1_q <= 1'b0;
            dly1_q    <= '0;
            dly2_q    <= '0;
            dly3_q    <= '0;
            comb_p2_q <= '0;
            vld_p2_q  <= 1'b0;
            last_p2_q <= 1'b0;
            ovf_q     <= 1'b0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
        end else begin
            int1_q    <= int1_d;
            int2_q    <= int2_d;
            int3_q    <= int3_d;
            cnt_q     <= cnt_d;
            vld_p1_q  <= vld_p1_d;
            last_p1_q <= last_p1_d;
            dly1_q    <= dly1_d;
            dly2_q    <= dly2_d;
            dly3_q    <= dly3_d;
            comb_p2_q <= comb_p2_d;
            vld_p2_q  <= vld_p2_d;
            last_p2_q <= last_p2_d;
            ovf_q     <= ovf_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
        end
    end

    assign wb.ack   = ack_q;
    assign wb.dat_r = dat_q;
    assign wb.stall = 1'b0;
    assign irq_o    = !fifo_empty;

    assign unused_wdat = ^{wb.dat_w[31:STAT_OVF+1], wb.dat_w[STAT_OVF-1:0]};

endmodule

// File: doc/wb_pdm_decim.md
# wb_pdm_decim

PDM-to-PCM decimation stage with a Wishbone B4 pipelined read port. It consumes the 1-bit microphone bitstream produced by the PDM capture stage, one bit per `pdm_stb_i` pulse. A 3rd-order CIC filter decimates the stream by `DECIM` and produces signed PCM samples. Samples are buffered in a FIFO that the CPU drains over Wishbone.

## Interface
- `DECIM`, 64: decimation ratio R; power of two, ≥4.
- `AUDIO_BIT_DEPTH`, 16: PCM sample width, signed.
- `FIFO_DEPTH`, 16: sample FIFO entries; power of two.
- `wb_clk_i` in 1: single clock for the whole block.
- `wb_rst_ni` in 1: reset, synchronous, active-low.
- `wb_cyc_i` in 1: Wishbone cycle.
- `wb_stb_i` in 1: Wishbone strobe.
- `wb_we_i` in 1: write enable.
- `wb_adr_i` in 1: register select; 0 = DATA, 1 = STATUS.
- `wb_dat_i` in 32: write data.
- `wb_dat_o` out 32: read data, registered.
- `wb_stall_o` out 1: tied 0.
- `wb_ack_o` out 1: acknowledge.
- `pdm_stb_i` in 1: one-cycle pulse per captured PDM bit.
- `pdm_dat_i` in 1: PDM bit, valid while `pdm_stb_i` is high.
- `irq_o` out 1: high while FIFO is not empty.

## Operation
- **Input mapping:** on `pdm_stb_i`, bit 1 → +1, bit 0 → −1.
- **Internal width:** W = 3·log2(DECIM)+1 bits, two's complement. Integrators wrap modulo 2^W, which is correct CIC behaviour.
- **Integrators:** 3 cascaded accumulators, updated only on `pdm_stb_i`.
- **Decimation counter:** 0..DECIM−1, incremented on `pdm_stb_i`. The strobe at count DECIM−1 raises an internal `tick` in the next cycle and wraps the counter to 0.
- **Combs:** 3 comb stages, each y = x − x_delayed by one decimated sample, evaluated on `tick`, result registered.
- **Output scaling:** take the comb output's top `AUDIO_BIT_DEPTH` bits, i.e. arithmetic right shift by W−AUDIO_BIT_DEPTH.
  - The single overflow case, +R³, saturates to max positive (0x7FFF for 16 bits).
  - −R³ maps to min negative (0x8000).
- **FIFO:** each scaled sample is pushed; data is sign-extended to 32 bits on read.
- **Full FIFO:** push without a same-cycle pop is dropped and sets sticky `ovf`.
- **Simultaneous push and pop:** both take effect and level is unchanged, including when the FIFO is full.
- **DATA read (adr 0):**
  - Non-empty FIFO: returns the head sample and pops it on the strobe cycle.
  - Empty FIFO: returns 0 with no pop.
- **STATUS read (adr 1):**
  - [15:0] level, zero-extended.
  - [16] empty.
  - [17] full.
  - [24] ovf.
  - Other bits 0.
- **Writes:** writing 1 to bit 24 of STATUS clears `ovf`. All other write bits, and all DATA writes, are ignored but still acknowledged.
- **Set/clear collision:** if `ovf` set and clear occur in the same cycle, set wins.

## Timing
- **Reset values:** integrators, combs, comb delays, decimation counter, FIFO pointers and level = 0; `ovf` = 0; `wb_ack_o` = 0; `wb_dat_o` = 0; `irq_o` = 0.
- **Reset mid-window:** discards the partial window and all buffered samples.
- **Wishbone:**
  - `wb_ack_o` is asserted exactly one cycle after each cycle where `wb_cyc_i && wb_stb_i`.
  - `wb_dat_o` is valid in the ack cycle.
  - Back-to-back strobes are accepted every cycle.
- **Sample latency:** for the strobe completing a window in cycle N:
  - `tick` in N+1.
  - Comb result registered at the end of N+1.
  - FIFO push in N+2.
  - Level and `irq_o` update at the end of N+2.
- **Warm-up:** the first 2 output samples after reset are transient. From the 3rd sample on, output equals the exact CIC response of the input.
- **Strobe spacing:** `pdm_stb_i` may pulse every cycle (back-to-back); the pipeline accepts this.
- **Pop timing:** a pop in cycle M lowers level at the end of M. A STATUS read in M+1 sees the new level.

## Structure
- **Shared package `wb_pdm_pkg`:**
  - Register address constants `ADR_DATA`, `ADR_STATUS`.
  - STATUS bit positions.
  - Function computing W from `DECIM`.
- **Sub-module `pcm_fifo`:** synchronous FIFO, parameterised on width and depth.
  - Inputs: push, pop.
  - Outputs: head data, level, full, empty.
  - Behaviour: drop-on-full unless popping in the same cycle.
- **Top level:** CIC datapath and Wishbone decode.

## Test plan
All cases use `DECIM`=64, depth 16, 16-bit samples, W=19.
- **All-ones input:** 3·64 strobes of `pdm_dat_i`=1, then continuous → samples 3 onward read 0x00007FFF (saturated).
- **All-zeros input:** continuous `pdm_dat_i`=0 → samples 3 onward read 0xFFFF8000.
- **Alternating input:** continuous 1,0,1,0… → samples 3 onward read 0x00000000.
- **Overflow:** no reads for 17 windows → STATUS = 0x01020010; first DATA read returns sample 1; level drops to 15; write 0x01000000 to STATUS → bit 24 clears.
- **Empty read:** DATA read on empty FIFO → ack in the next cycle, data 0, level stays 0, `irq_o` stays 0. Back-to-back DATA+STATUS strobes → two consecutive acks.
- **Reset mid-operation:** assert `wb_rst_ni`=0 for 1 cycle mid-window with 5 samples buffered → STATUS = 0x00010000; the next samples show the warm-up transient again.
